// File: rtl/exe_unit_w1_pkg.sv
// Shared opcode encodings, status-bit positions and flag packing for the
// single-cycle execution unit.
package exe_unit_w1_pkg;

    localparam int unsigned OP_ADD = 32'd0;
    localparam int unsigned OP_SLT = 32'd1;
    localparam int unsigned OP_SUB = 32'd2;
    localparam int unsigned OP_XOR = 32'd3;

    localparam int unsigned ST_Z = 32'd0;
    localparam int unsigned ST_N = 32'd1;
    localparam int unsigned ST_V = 32'd2;
    localparam int unsigned ST_C = 32'd3;

    function automatic logic [3:0] pack_status(input logic c, input logic v,
                                               input logic n, input logic z);
        logic [3:0] st;
        st       = 4'b0000;
        st[ST_C] = c;
        st[ST_V] = v;
        st[ST_N] = n;
        st[ST_Z] = z;
        return st;
    endfunction

endpackage

// File: rtl/exe_unit_w1_alu.sv
// Combinational datapath: one shared m+1-bit adder serves ADD, SUB and SLT;
// subtraction is performed as A + ~B + 1.
module exe_unit_w1_alu
    import exe_unit_w1_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic [n-1:0] oper,
    input  logic [m-1:0] arg_a,
    input  logic [m-1:0] arg_b,
    output logic [m-1:0] result,
    output logic [3:0]   status,
    output logic         valid
);

    logic         sub_s;
    logic [m-1:0] b_eff_s;
    logic [m:0]   sum_s;
    logic         ovf_s;
    logic         lt_s;
    logic         c_s;
    logic         v_s;
    logic [m-1:0] res_s;

    // Shared adder; overflow rule covers SUB because B is already inverted
    always_comb begin
        sub_s   = (32'(oper) == OP_SUB) || (32'(oper) == OP_SLT);
        b_eff_s = sub_s ? ~arg_b : arg_b;
        sum_s   = {1'b0, arg_a} + {1'b0, b_eff_s} + {{m{1'b0}}, sub_s};
        ovf_s   = (arg_a[m-1] == b_eff_s[m-1]) && (sum_s[m-1] != arg_a[m-1]);
        lt_s    = sum_s[m-1] ^ ovf_s;
    end

    // Opcode select; carry out of the adder is inverted into a borrow for SUB
    always_comb begin
        res_s = {m{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        valid = 1'b1;
        case (32'(oper))
            OP_ADD: begin
                res_s = sum_s[m-1:0];
                c_s   = sum_s[m];
                v_s   = ovf_s;
            end
            OP_SLT: begin
                res_s = {{(m-1){1'b0}}, lt_s};
            end
            OP_SUB: begin
                res_s = sum_s[m-1:0];
                c_s   = ~sum_s[m];
                v_s   = ovf_s;
            end
            OP_XOR: begin
                res_s = arg_a ^ arg_b;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
        result = res_s;
        status = pack_status(c_s, v_s, res_s[m-1], res_s == {m{1'b0}});
    end

endmodule

// File: rtl/exe_unit_w1_core.sv
// Registered execution unit: ALU outputs captured each clock when the opcode
// is valid; invalid opcodes leave the previous result and flags in place.
module exe_unit_w1_core
    import exe_unit_w1_pkg::*;
#(
    parameter int m = 4,
    parameter int n = 2
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic [n-1:0] i_oper,
    input  logic [m-1:0] i_argA,
    input  logic [m-1:0] i_argB,
    output logic [m-1:0] o_result,
    output logic [3:0]   o_status
);

    logic [m-1:0] alu_result_s;
    logic [3:0]   alu_status_s;
    logic         alu_valid_s;
    logic [m-1:0] result_r;
    logic [3:0]   status_r;

    exe_unit_w1_alu #(
        .m(m),
        .n(n)
    ) u_alu (
        .oper   (i_oper),
        .arg_a  (i_argA),
        .arg_b  (i_argB),
        .result (alu_result_s),
        .status (alu_status_s),
        .valid  (alu_valid_s)
    );

    // Output registers with asynchronous clear, loaded only on valid opcodes
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            result_r <= {m{1'b0}};
            status_r <= 4'b0000;
        end else if (alu_valid_s) begin
            result_r <= alu_result_s;
            status_r <= alu_status_s;
        end else begin
            result_r <= result_r;
            status_r <= status_r;
        end
    end

    assign o_result = result_r;
    assign o_status = status_r;

endmodule

// File: tb/tb_exe_unit_w1_core.sv
// Bench for exe_unit_w1_core: an n=2 and an n=3 instance share one operand
// stream; an integer-arithmetic model tracks both, plus literal expectations.
module tb_exe_unit_w1_core;

    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rsn = 1'b1;
    logic [2:0]   oper = 3'd0;
    logic [M-1:0] arg_a = 4'd0;
    logic [M-1:0] arg_b = 4'd0;
    logic [M-1:0] res2, res3;
    logic [3:0]   st2, st3;
    logic [M-1:0] e_res2 = 4'd0, e_res3 = 4'd0;
    logic [3:0]   e_st2 = 4'd0, e_st3 = 4'd0;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    exe_unit_w1_core #(.m(M), .n(2)) dut2 (
        .i_clk(clk), .i_rsn(rsn), .i_oper(oper[1:0]),
        .i_argA(arg_a), .i_argB(arg_b), .o_result(res2), .o_status(st2));

    exe_unit_w1_core #(.m(M), .n(3)) dut3 (
        .i_clk(clk), .i_rsn(rsn), .i_oper(oper),
        .i_argA(arg_a), .i_argB(arg_b), .o_result(res3), .o_status(st3));

    function automatic void model(input int op, input logic [M-1:0] a, input logic [M-1:0] b,
                                  output bit ok, output logic [M-1:0] r, output logic [3:0] st);
        int sa = $signed(a);
        int sb = $signed(b);
        int ua = int'(a);
        int ub = int'(b);
        int lo = -(1 << (M-1));
        int hi = (1 << (M-1)) - 1;
        int full = 0;
        bit c = 1'b0;
        bit v = 1'b0;
        ok = 1'b1;
        r  = '0;
        case (op)
            0: begin full = ua + ub; c = (full >= (1 << M)); v = (sa + sb > hi) || (sa + sb < lo); r = M'(full); end
            1: r = (sa < sb) ? 4'd1 : 4'd0;
            2: begin full = ua - ub; c = (ua < ub); v = (sa - sb > hi) || (sa - sb < lo); r = M'(full); end
            3: r = a ^ b;
            default: ok = 1'b0;
        endcase
        st = {c, v, r[M-1], (r == '0)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference state: cleared by reset, updated at each edge only on valid opcodes
    always @(posedge clk or negedge rsn) begin : ref_model
        bit ok;
        logic [M-1:0] r;
        logic [3:0] s;
        if (!rsn) begin
            e_res2 <= '0; e_st2 <= '0; e_res3 <= '0; e_st3 <= '0;
        end else begin
            model(int'(oper[1:0]), arg_a, arg_b, ok, r, s);
            if (ok) begin e_res2 <= r; e_st2 <= s; end
            model(int'(oper), arg_a, arg_b, ok, r, s);
            if (ok) begin e_res3 <= r; e_st3 <= s; end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("model_res2", 8'(res2), 8'(e_res2));
        check("model_st2",  8'(st2),  8'(e_st2));
        check("model_res3", 8'(res3), 8'(e_res3));
        check("model_st3",  8'(st3),  8'(e_st3));
    end

    task automatic apply(input logic [2:0] op, input logic [M-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        oper  = op;
        arg_a = a;
        arg_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_both(input string name, input logic [M-1:0] r, input logic [3:0] s);
        check({name, "_res2"}, 8'(res2), 8'(r));
        check({name, "_st2"},  8'(st2),  8'(s));
        check({name, "_res3"}, 8'(res3), 8'(r));
        check({name, "_st3"},  8'(st3),  8'(s));
    endtask

    initial begin
        #1;
        rsn   = 1'b0;
        arg_a = 4'b0111;
        arg_b = 4'b1111;
        #1;
        expect_both("rst_async", 4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        expect_both("rst_edge", 4'b0000, 4'b0000);
        @(negedge clk);
        rsn = 1'b1;

        apply(3'd0, 4'b0111, 4'b0011);
        expect_both("add_ovf", 4'b1010, 4'b0110);
        #1;
        rsn = 1'b0;
        #1;
        expect_both("rst_mid", 4'b0000, 4'b0000);
        @(negedge clk);
        rsn = 1'b1;

        apply(3'd2, 4'b0000, 4'b0011);
        expect_both("sub_borrow", 4'b1101, 4'b1010);
        apply(3'd2, 4'b1101, 4'b0011);
        expect_both("sub_neg", 4'b1010, 4'b0010);
        apply(3'd1, 4'b1101, 4'b0011);
        expect_both("slt", 4'b0001, 4'b0000);
        apply(3'd3, 4'b1101, 4'b0011);
        expect_both("xor", 4'b1110, 4'b0010);
        apply(3'd3, 4'b0101, 4'b0101);
        expect_both("xor_zero", 4'b0000, 4'b0001);
        apply(3'd0, 4'b1111, 4'b0001);
        expect_both("add_carry", 4'b0000, 4'b1001);
        apply(3'd2, 4'b1000, 4'b0001);
        expect_both("sub_ovf", 4'b0111, 4'b0100);
        apply(3'd1, 4'b0011, 4'b1101);
        expect_both("slt_false", 4'b0000, 4'b0001);

        apply(3'd0, 4'b0001, 4'b0001);
        expect_both("add_small", 4'b0010, 4'b0000);
        apply(3'd4, 4'b0001, 4'b0001);
        check("inv_hold_res3", 8'(res3), 8'b0000_0010);
        check("inv_hold_st3",  8'(st3),  8'b0000_0000);
        #2;
        arg_a = 4'b0110;
        arg_b = 4'b0101;
        #2;
        check("inv_midcycle_res3", 8'(res3), 8'b0000_0010);
        check("inv_midcycle_res2", 8'(res2), 8'b0000_0010);
        @(posedge clk);
        #1;
        check("inv_hold2_res3", 8'(res3), 8'b0000_0010);
        check("inv_hold2_st3",  8'(st3),  8'b0000_0000);
        check("n2_add_res2",    8'(res2), 8'b0000_1011);
        check("n2_add_st2",     8'(st2),  8'b0000_0110);

        apply(3'd2, 4'b0011, 4'b0011);
        expect_both("sub_zero", 4'b0000, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
